// File: rtl/updi_instruction_arbiter.sv
// rtl/updi_instruction_arbiter.sv - round-robin arbiter sharing one UPDI instruction queue handler
module updi_instruction_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int REQ_BITS       = $clog2(NUM_REQ)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req,
    input  logic [NUM_REQ-1:0][7:0]                    req_opcode,
    input  logic [NUM_REQ-1:0][MAX_DATA_SIZE-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0][DATA_ADDR_BITS:0]       req_data_len,
    input  logic [NUM_REQ-1:0][MAX_DATA_SIZE-1:0]      req_wait_ack_after,
    output logic [NUM_REQ-1:0]                         gnt,
    output logic [NUM_REQ-1:0]                         done,
    output logic [NUM_REQ-1:0]                         ack_wait,
    output logic [REQ_BITS-1:0]                        grant_id,
    output logic                                       busy,
    output logic                                       hdl_start,
    input  logic                                       hdl_ready,
    input  logic                                       hdl_waiting_for_ack,
    output logic [7:0]                                 hdl_opcode,
    output logic [MAX_DATA_SIZE-1:0][7:0]              hdl_data,
    output logic [DATA_ADDR_BITS:0]                    hdl_data_len,
    output logic [MAX_DATA_SIZE-1:0]                   hdl_wait_ack_after
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [NUM_REQ-1:0]              gnt_q, gnt_d;
    logic [NUM_REQ-1:0]              done_q, done_d;
    logic [REQ_BITS-1:0]             grant_id_q, grant_id_d;
    logic [REQ_BITS-1:0]             last_q, last_d;
    logic                            start_q, start_d;
    logic                            busy_q, busy_d;
    logic [7:0]                      opcode_q, opcode_d;
    logic [MAX_DATA_SIZE-1:0][7:0]   data_q, data_d;
    logic [DATA_ADDR_BITS:0]         len_q, len_d;
    logic [MAX_DATA_SIZE-1:0]        mask_q, mask_d;

    logic [REQ_BITS-1:0]             winner;
    logic                            found;

    // Search upward from the slot after the last owner, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[REQ_BITS'(idx)]) begin
                winner = REQ_BITS'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = done_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        start_d    = start_q;
        opcode_d   = opcode_q;
        data_d     = data_q;
        len_d      = len_q;
        mask_d     = mask_q;
        case (state_q)
            IDLE: begin
                if (found && hdl_ready) begin
                    state_d         = START;
                    gnt_d           = '0;
                    gnt_d[winner]   = 1'b1;
                    grant_id_d      = winner;
                    last_d          = winner;
                    start_d         = 1'b1;
                    opcode_d        = req_opcode[winner];
                    data_d          = req_data[winner];
                    len_d           = req_data_len[winner];
                    mask_d          = req_wait_ack_after[winner];
                end
            end
            // Start is held until the handler acknowledges it by dropping ready.
            START: begin
                if (!hdl_ready) begin
                    state_d = RUN;
                    start_d = 1'b0;
                end
            end
            RUN: begin
                if (hdl_ready) begin
                    state_d             = DONE;
                    done_d              = '0;
                    done_d[grant_id_q]  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            grant_id_q <= '0;
            last_q     <= REQ_BITS'(NUM_REQ - 1);
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            opcode_q   <= '0;
            data_q     <= '0;
            len_q      <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            opcode_q   <= opcode_d;
            data_q     <= data_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
        end
    end

    assign gnt                = gnt_q;
    assign done               = done_q;
    assign ack_wait           = gnt_q & {NUM_REQ{hdl_waiting_for_ack}};
    assign grant_id           = grant_id_q;
    assign busy               = busy_q;
    assign hdl_start          = start_q;
    assign hdl_opcode         = opcode_q;
    assign hdl_data           = data_q;
    assign hdl_data_len       = len_q;
    assign hdl_wait_ack_after = mask_q;

endmodule

// File: tb/tb_updi_instruction_arbiter.sv
// tb/tb_updi_instruction_arbiter.sv - self-checking bench for updi_instruction_arbiter
module tb_updi_instruction_arbiter;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [3:0]               req;
    logic [3:0][7:0]          req_opcode;
    logic [3:0][15:0][7:0]    req_data;
    logic [3:0][4:0]          req_data_len;
    logic [3:0][15:0]         req_wait_ack_after;
    logic [3:0]               gnt, done, ack_wait;
    logic [1:0]               grant_id;
    logic                     busy, hdl_start, hdl_ready, hdl_waiting_for_ack;
    logic [7:0]               hdl_opcode;
    logic [15:0][7:0]         hdl_data;
    logic [4:0]               hdl_data_len;
    logic [15:0]              hdl_wait_ack_after;

    int errors = 0;
    int checks = 0;
    int mlast  = 3;

    logic [7:0]       exp_op;
    logic [15:0][7:0] exp_data;
    logic [4:0]       exp_len;
    logic [15:0]      exp_mask;

    updi_instruction_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_opcode(req_opcode),
        .req_data(req_data), .req_data_len(req_data_len),
        .req_wait_ack_after(req_wait_ack_after), .gnt(gnt), .done(done),
        .ack_wait(ack_wait), .grant_id(grant_id), .busy(busy),
        .hdl_start(hdl_start), .hdl_ready(hdl_ready),
        .hdl_waiting_for_ack(hdl_waiting_for_ack), .hdl_opcode(hdl_opcode),
        .hdl_data(hdl_data), .hdl_data_len(hdl_data_len),
        .hdl_wait_ack_after(hdl_wait_ack_after)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first requester set, scanning upward from last+1 with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic randomize_payloads();
        for (int r = 0; r < 4; r++) begin
            req_opcode[r]         = 8'($urandom);
            for (int b = 0; b < 16; b++) req_data[r][b] = 8'($urandom);
            req_data_len[r]       = 5'($urandom_range(0, 16));
            req_wait_ack_after[r] = 16'($urandom);
        end
    endtask

    task automatic await_grant(input int id);
        int n;
        n        = 0;
        exp_op   = req_opcode[id];
        exp_data = req_data[id];
        exp_len  = req_data_len[id];
        exp_mask = req_wait_ack_after[id];
        while (gnt == 4'b0 && n < 20) begin
            step();
            n++;
            chk("no_done_before_grant", done, 4'b0);
        end
        chk("gnt", gnt, 4'b1 << id);
        chk("grant_id", grant_id, id);
        chk("hdl_start_on_grant", hdl_start, 1'b1);
        chk("busy_on_grant", busy, 1'b1);
        chk("hdl_opcode", hdl_opcode, exp_op);
        chk("hdl_data", hdl_data, exp_data);
        chk("hdl_data_len", hdl_data_len, exp_len);
        chk("hdl_wait_ack_after", hdl_wait_ack_after, exp_mask);
        mlast = id;
    endtask

    // Handler model: drops ready after seeing start, works run_cycles, then restores ready.
    task automatic serve(input int id, input int run_cycles);
        hdl_ready = 1'b0;
        step();
        chk("hdl_start_one_cycle", hdl_start, 1'b0);
        chk("gnt_hold", gnt, 4'b1 << id);
        chk("data_frozen", hdl_data, exp_data);
        for (int i = 0; i < run_cycles; i++) begin
            step();
            chk("no_done_in_run", done, 4'b0);
            chk("data_frozen", hdl_data, exp_data);
        end
        hdl_ready = 1'b1;
        step();
        chk("done_pulse", done, 4'b1 << id);
        chk("busy_in_done", busy, 1'b1);
        chk("data_frozen", hdl_data, exp_data);
        req[id] = 1'b0;
        step();
        chk("done_clear", done, 4'b0);
        chk("gnt_clear", gnt, 4'b0);
        chk("busy_idle", busy, 1'b0);
        chk("grant_id_kept", grant_id, id);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; hdl_ready = 1'b0; hdl_waiting_for_ack = 1'b0;
        req_opcode = '0; req_data = '0; req_data_len = '0; req_wait_ack_after = '0;
        #1;
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_opcode", hdl_opcode, 8'h0);
        step();

        // Handler not ready after reset: nothing is granted.
        randomize_payloads();
        req   = 4'b0010;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("notready_gnt", gnt, 4'b0);
            chk("notready_start", hdl_start, 1'b0);
            chk("notready_busy", busy, 1'b0);
            chk("notready_done", done, 4'b0);
        end
        hdl_ready = 1'b1;
        await_grant(rr_pick(req, mlast));
        serve(1, 2);

        // Single zero-length instruction.
        req_opcode[0] = 8'hC3; req_data_len[0] = 5'd0; req = 4'b0001;
        await_grant(rr_pick(req, mlast));
        chk("zero_len_opcode", hdl_opcode, 8'hC3);
        serve(0, 3);

        // Contention from a fresh pointer: expected order 0, 1, 3.
        rst_n = 1'b0; step(); rst_n = 1'b1; mlast = 3;
        randomize_payloads();
        req = 4'b1011;
        await_grant(rr_pick(req, mlast)); chk("order0", grant_id, 2'd0); serve(0, 1);
        await_grant(rr_pick(req, mlast)); chk("order1", grant_id, 2'd1); serve(1, 0);
        await_grant(rr_pick(req, mlast)); chk("order2", grant_id, 2'd3); serve(3, 2);

        // Payload latching across a requester-side change.
        req_data[2][0] = 8'hAA; req = 4'b0100;
        await_grant(rr_pick(req, mlast));
        chk("latch_aa", hdl_data[0], 8'hAA);
        req_data[2][0] = 8'h55;
        serve(2, 3);

        // ACK routing only to the owner.
        hdl_waiting_for_ack = 1'b1;
        #1 chk("ack_idle", ack_wait, 4'b0);
        hdl_waiting_for_ack = 1'b0;
        req = 4'b0010;
        await_grant(rr_pick(req, mlast));
        hdl_ready = 1'b0;
        step();
        chk("ack_before", ack_wait, 4'b0);
        hdl_waiting_for_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ack_owner", ack_wait, 4'b0010);
            @(posedge clk);
            #1;
        end
        hdl_waiting_for_ack = 1'b0;
        #1 chk("ack_after", ack_wait, 4'b0);
        hdl_ready = 1'b1;
        step();
        chk("ack_done", done, 4'b0010);
        req = 4'b0;
        step();
        chk("ack_gnt_clear", gnt, 4'b0);

        // Reset while the handler is running.
        req = 4'b0001;
        await_grant(rr_pick(req, mlast));
        hdl_ready = 1'b0;
        step();
        req   = 4'b0100;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 4'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 4'b0);
        chk("async_start", hdl_start, 1'b0);
        chk("async_grant_id", grant_id, 2'd0);
        mlast = 3;
        step(); step();
        rst_n = 1'b1; hdl_ready = 1'b1;
        await_grant(rr_pick(req, mlast));
        serve(2, 1);

        // Randomized request patterns against the round-robin rule.
        for (int it = 0; it < 25; it++) begin
            req = 4'($urandom_range(1, 15));
            while (req != 4'b0) begin
                randomize_payloads();
                await_grant(rr_pick(req, mlast));
                if ($urandom_range(0, 1) == 1) randomize_payloads();
                serve(mlast, $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
